mc_ctrl_fsm: RTL

//  Multicycle MIPS control sequencer: one shared ALU/memory datapath is driven

---
 rtl/mc_ctrl_if.sv | 53 +++++
 rtl/mc_ctrl_fsm.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_if.sv
// ============================================================================
// Module   : mc_ctrl_if
// Brief    : Control/status bundle between the multicycle MIPS sequencer and
//            its shared ALU/memory datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;

    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemtoReg;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSource;

    logic             busy;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] instr_retired;

    // Sequencer side
    modport master (
        input  run, opcode, zero, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               busy, err, err_code, instr_retired
    );

    // Datapath / host side
    modport slave (
        output run, opcode, zero, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               busy, err, err_code, instr_retired
    );
endinterface

`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
// ============================================================================
// Module   : mc_ctrl_fsm
// Brief    : Multicycle MIPS control sequencer with memory-wait timeout trap,
//            illegal-opcode trap and retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    mc_ctrl_if.master  bus
);

    localparam int              c_WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;

    localparam logic [1:0] c_ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12,
        S_ERR    = 4'd13
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]    r_retired;
    logic                r_err;
    logic [1:0]          r_err_code;

    logic       w_retire;
    logic       w_wait_inc;
    logic       w_trap_illegal;
    logic       w_trap_timeout;
    logic       w_timeout;

    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_mem_to_reg;
    logic       w_reg_dst;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_source;

    // Final waiting cycle with no completion; a same-cycle mem_ready still wins.
    assign w_timeout = !bus.mem_ready && (r_wait_cnt == c_WAIT_LAST);

    always_comb begin
        w_next          = r_state;
        w_retire        = 1'b0;
        w_wait_inc      = 1'b0;
        w_trap_illegal  = 1'b0;
        w_trap_timeout  = 1'b0;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_dst       = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_op        = 2'b00;
        w_pc_source     = 2'b00;

        case (r_state)
            S_IDLE: begin
                if (bus.run) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout) begin
                    w_trap_timeout = 1'b1;
                    w_next         = S_ERR;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                case (bus.opcode)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_RTYPE:       w_next = S_EXEC;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_J:           w_next = S_JUMP;
                    c_OP_ADDI:        w_next = S_ADDIEX;
                    default: begin
                        w_trap_illegal = 1'b1;
                        w_next         = S_ERR;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = (bus.opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                if (bus.mem_ready) begin
                    w_next = S_MEMWB;
                end else if (w_timeout) begin
                    w_trap_timeout = 1'b1;
                    w_next         = S_ERR;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_retire     = 1'b1;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                if (bus.mem_ready) begin
                    w_retire = 1'b1;
                end else if (w_timeout) begin
                    w_trap_timeout = 1'b1;
                    w_next         = S_ERR;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
                w_next      = S_RWB;
            end
            S_RWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                w_retire    = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
                w_retire        = 1'b1;
            end
            S_JUMP: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
                w_retire    = 1'b1;
            end
            S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_ERR: begin
                w_next = S_ERR;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // run is only looked at on the instruction boundary
        if (w_retire) w_next = bus.run ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_retired  <= '0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_inc ? r_wait_cnt + 1'b1 : '0;
            if (w_retire) r_retired <= r_retired + 1'b1;
            if (w_trap_illegal) begin
                r_err      <= 1'b1;
                r_err_code <= c_ERR_ILLEGAL;
            end else if (w_trap_timeout) begin
                r_err      <= 1'b1;
                r_err_code <= c_ERR_TIMEOUT;
            end
        end
    end

    assign bus.PCWrite       = w_pc_write;
    assign bus.PCWriteCond   = w_pc_write_cond;
    assign bus.IorD          = w_iord;
    assign bus.MemRead       = w_mem_read;
    assign bus.MemWrite      = w_mem_write;
    assign bus.IRWrite       = w_ir_write;
    assign bus.MemtoReg      = w_mem_to_reg;
    assign bus.RegDst        = w_reg_dst;
    assign bus.RegWrite      = w_reg_write;
    assign bus.ALUSrcA       = w_alu_src_a;
    assign bus.ALUSrcB       = w_alu_src_b;
    assign bus.ALUOp         = w_alu_op;
    assign bus.PCSource      = w_pc_source;
    assign bus.busy          = (r_state != S_IDLE) && (r_state != S_ERR);
    assign bus.err           = r_err;
    assign bus.err_code      = r_err_code;
    assign bus.instr_retired = r_retired;

endmodule

`default_nettype wire
